// File: rtl/lbist_pkg.sv
// LBIST shared types and constants.
// galois_step serves both the PRPG and the MISR.
package lbist_pkg;

    localparam int unsigned LFSR_MAX_W = 64;

    localparam logic [31:0] PRPG_POLY_DEF  = 32'h80200003;
    localparam logic [31:0] PRPG_SEED_DEF  = 32'h00000001;
    localparam logic [31:0] MISR_POLY_DEF  = 32'h80200003;
    localparam logic [31:0] GOLDEN_SIG_DEF = 32'h00000000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        CMP,
        DONE
    } state_e;

    // Narrower registers are zero-extended, so the top bit shifts in 0.
    function automatic logic [LFSR_MAX_W-1:0] galois_step(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Galois LFSR with load and XOR injection.
// Used as PRPG (xor_in = 0) and as MISR (xor_in = response).
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int unsigned  W       = 32,
    parameter logic [W-1:0] POLY    = '0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] xor_in_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = W'(galois_step(LFSR_MAX_W'(state_q),
                                     LFSR_MAX_W'(POLY))) ^ xor_in_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: PRPG stimulus, MISR compaction,
// golden-signature compare and go/no-go reporting.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned       PAT_W      = 32,
    parameter int unsigned       RESP_W     = 32,
    parameter int unsigned       N_PATTERNS = 1024,
    parameter int unsigned       CUT_LAT    = 1,
    parameter logic [PAT_W-1:0]  PRPG_POLY  = PAT_W'(PRPG_POLY_DEF),
    parameter logic [PAT_W-1:0]  PRPG_SEED  = PAT_W'(PRPG_SEED_DEF),
    parameter logic [RESP_W-1:0] MISR_POLY  = RESP_W'(MISR_POLY_DEF),
    parameter logic [RESP_W-1:0] GOLDEN_SIG = RESP_W'(GOLDEN_SIG_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [RESP_W-1:0] cut_resp_i,
    output logic              test_mode_o,
    output logic [PAT_W-1:0]  prpg_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              go_nogo_o,
    output logic [RESP_W-1:0] signature_o
);

    localparam int unsigned CNT_W = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);
    localparam logic [2:0] LAT_LAST = 3'(CUT_LAT - 1);
    localparam logic [PAT_W-1:0] SEED_EFF =
        (PRPG_SEED == '0) ? PAT_W'(1) : PRPG_SEED;

    state_e            state_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        lat_q;
    logic              tm_q;
    logic              busy_q;
    logic              done_q;
    logic              go_q;
    logic [RESP_W-1:0] sig_q;

    logic              rise;
    logic              run;
    logic              init;
    logic              vld;
    logic [PAT_W-1:0]  prpg;
    logic [RESP_W-1:0] misr;

    assign rise = start_i & ~start_q;
    assign run  = (state_q == RUN);
    assign init = (state_q == INIT);

    lbist_lfsr #(
        .W       (PAT_W),
        .POLY    (PRPG_POLY),
        .RST_VAL (PRPG_SEED)
    ) u_prpg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (init),
        .load_val_i (SEED_EFF),
        .en_i       (run),
        .xor_in_i   ('0),
        .state_o    (prpg)
    );

    lbist_lfsr #(
        .W       (RESP_W),
        .POLY    (MISR_POLY),
        .RST_VAL ('0)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (init),
        .load_val_i ('0),
        .en_i       (vld),
        .xor_in_i   (cut_resp_i),
        .state_o    (misr)
    );

    // Valid marker travels alongside the pattern through the CUT pipe.
    if (CUT_LAT == 0) begin : g_nolat
        assign vld = run;
    end else begin : g_lat
        logic [CUT_LAT-1:0] vsr_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vsr_q <= '0;
            end else begin
                vsr_q <= (vsr_q << 1) | CUT_LAT'(run);
            end
        end
        assign vld = vsr_q[CUT_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            sig_q   <= '0;
        end else begin
            start_q <= start_i;
            unique case (state_q)
                IDLE, DONE: begin
                    if (rise) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        go_q    <= 1'b0;
                    end
                end
                INIT: begin
                    state_q <= RUN;
                    tm_q    <= 1'b1;
                    cnt_q   <= '0;
                    lat_q   <= '0;
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (CUT_LAT == 0) begin
                            state_q <= CMP;
                            tm_q    <= 1'b0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    lat_q <= lat_q + 3'd1;
                    if (lat_q == LAT_LAST) begin
                        state_q <= CMP;
                        tm_q    <= 1'b0;
                    end
                end
                CMP: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    go_q    <= (misr == GOLDEN_SIG);
                    sig_q   <= misr;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign test_mode_o = tm_q;
    assign prpg_o      = run ? prpg : '0;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign go_nogo_o   = go_q;
    assign signature_o = sig_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl over three parameter sets:
// N=4/LAT=1, N=1/LAT=0 and N=1/LAT=3.
module tb_lbist_ctrl;

    localparam logic [31:0] POLY = 32'h80200003;
    // MISR of the four loopback words 1, 80200003, C0300002, 60180001
    localparam logic [31:0] GOLD = 32'h00000000;
    localparam int WIN = 26;
    localparam logic [31:0] EXP_PAT [4] = '{
        32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [3];
    logic [31:0] resp_v  [3];
    logic        tm      [3];
    logic        busy    [3];
    logic        done    [3];
    logic        go      [3];
    logic [31:0] prpg    [3];
    logic [31:0] sig     [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NP = (g == 0) ? 4 : 1;
        localparam int LT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        lbist_ctrl #(
            .N_PATTERNS (NP),
            .CUT_LAT    (LT),
            .GOLDEN_SIG (GOLD)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_i     (start_v[g]),
            .cut_resp_i  (resp_v[g]),
            .test_mode_o (tm[g]),
            .prpg_o      (prpg[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .go_nogo_o   (go[g]),
            .signature_o (sig[g])
        );
    end

    typedef struct {
        int u;
        int mode;
        bit flip;
        int hold;
        bit mid;
        int e_run;
        int e_drain;
        int e_done;
        int e_go;
    } vec_t;

    function automatic int nof(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int latof(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] m,
                                              input logic [31:0] r);
        return ((m >> 1) ^ (m[0] ? POLY : 32'h0)) ^ r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input int u);
        chk($sformatf("zero_tm%0d", u), 32'(tm[u]), 32'h0);
        chk($sformatf("zero_busy%0d", u), 32'(busy[u]), 32'h0);
        chk($sformatf("zero_done%0d", u), 32'(done[u]), 32'h0);
        chk($sformatf("zero_go%0d", u), 32'(go[u]), 32'h0);
        chk($sformatf("zero_prpg%0d", u), prpg[u], 32'h0);
        chk($sformatf("zero_sig%0d", u), sig[u], 32'h0);
    endtask

    task automatic run_unit(input vec_t v);
        int n, lat, rc, dc, tmc, bc, hd, done_c;
        logic [31:0] rv [WIN];
        logic [31:0] prev, m;
        n = nof(v.u);
        lat = latof(v.u);
        rc = 0; dc = 0; tmc = 0; bc = 0; hd = 0; done_c = -1;
        prev = '0;
        @(negedge clk);
        start_v[v.u] = 1'b1;
        for (int c = 0; c < WIN; c++) begin
            @(posedge clk);
            #1;
            start_v[v.u] = (c + 1 < v.hold) || (v.mid && c == 1);
            if (v.mode == 0)
                rv[c] = prev ^ ((v.flip && c == 2 + lat) ? 32'h1 : 32'h0);
            else
                rv[c] = $urandom;
            resp_v[v.u] = rv[c];
            @(negedge clk);
            if (c == 0) begin
                chk("init_done_clear", 32'(done[v.u]), 32'h0);
                chk("init_busy", 32'(busy[v.u]), 32'h1);
            end
            if (prpg[v.u] != 32'h0) begin
                if (rc < n)
                    chk($sformatf("prpg%0d", rc), prpg[v.u], EXP_PAT[rc]);
                rc++;
            end else if (tm[v.u]) begin
                dc++;
            end
            tmc += int'(tm[v.u]);
            bc += int'(busy[v.u]);
            if (done[v.u]) begin
                hd++;
                if (done_c < 0) done_c = c;
            end
            prev = prpg[v.u];
        end
        resp_v[v.u] = '0;
        m = '0;
        for (int k = 0; k < n; k++) m = misr_next(m, rv[1 + k + lat]);
        chk("run_cycles", rc, v.e_run);
        chk("drain_cycles", dc, v.e_drain);
        chk("test_mode_cycles", tmc, n + lat);
        chk("busy_cycles", bc, n + lat + 2);
        chk("done_cycle", done_c, v.e_done);
        chk("done_held", hd, WIN - v.e_done);
        chk("signature", sig[v.u], m);
        chk("go_model", 32'(go[v.u]), 32'(m == GOLD));
        if (v.e_go >= 0) chk("go_table", 32'(go[v.u]), v.e_go);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t rv;
        tbl[0] = '{0, 0, 1'b0, 1,  1'b0, 4, 1, 7, 1};
        tbl[1] = '{0, 0, 1'b1, 1,  1'b0, 4, 1, 7, 0};
        tbl[2] = '{0, 0, 1'b0, 1,  1'b1, 4, 1, 7, 1};
        tbl[3] = '{0, 0, 1'b0, 20, 1'b0, 4, 1, 7, 1};
        tbl[4] = '{1, 1, 1'b0, 1,  1'b0, 1, 0, 3, -1};
        tbl[5] = '{2, 1, 1'b0, 1,  1'b0, 1, 3, 6, -1};
        tbl[6] = '{0, 1, 1'b0, 1,  1'b0, 4, 1, 7, -1};
        tbl[7] = '{0, 0, 1'b0, 1,  1'b0, 4, 1, 7, 1};

        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            resp_v[u] = '0;
        end
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) check_zero(u);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_unit(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rv.u = int'($urandom_range(0, 2));
            rv.mode = 1;
            rv.flip = 1'b0;
            rv.hold = 1;
            rv.mid = 1'b0;
            rv.e_run = nof(rv.u);
            rv.e_drain = latof(rv.u);
            rv.e_done = nof(rv.u) + latof(rv.u) + 2;
            rv.e_go = -1;
            run_unit(rv);
        end

        // Reset during the second RUN cycle, then a clean rerun.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_prpg", prpg[0], EXP_PAT[1]);
        rst_n = 1'b0;
        #1;
        check_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_unit(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbist_ctrl.md
Name: lbist_ctrl

Overview:
- Logic-BIST controller that drives the core wrapper's start/go_nogo LBIST pair.
- On a start request it generates N_PATTERNS pseudo-random stimuli with an LFSR (PRPG) and presents them to the circuit-under-test (CUT).
- It compacts the CUT responses in a MISR and compares the final signature against a golden value.
- It reports go/no-go upward to the wrapper and the testbench, which use it as a pass/fail flag alongside the software exit status.

Parameters:
- PAT_W, 32, PRPG/pattern width (bits).
- RESP_W, 32, CUT response and MISR width (bits).
- N_PATTERNS, 1024, number of patterns per run (>=1).
- CUT_LAT, 1, cycles from prpg_o to the matching cut_resp_i (0..7).
- PRPG_POLY, 32'h80200003, Galois feedback constant for the PRPG.
- PRPG_SEED, 32'h00000001, PRPG initial state.
- MISR_POLY, 32'h80200003, Galois feedback constant for the MISR.
- GOLDEN_SIG, 32'h00000000, expected final MISR signature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  run request, rising-edge detected
- cut_resp_i  in  RESP_W  CUT response
- test_mode_o  out  1  CUT in test mode (RUN and DRAIN states)
- prpg_o  out  PAT_W  current pattern
- busy_o  out  1  run in progress
- done_o  out  1  result valid
- go_nogo_o  out  1  1 = signature matched (go), 0 = mismatch or no result
- signature_o  out  RESP_W  final MISR value

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state is on posedge clk.
- Reset values: FSM=IDLE, all outputs 0, PRPG=PRPG_SEED, MISR=0, counter=0, start edge register=0.
- start edge: rise = start_i & ~start_q. A rise is accepted only in IDLE or DONE; it is ignored in INIT, RUN, DRAIN and CMP.
- FSM states and transitions:
  - IDLE -> INIT on rise.
  - INIT (1 cycle): PRPG<=seed, MISR<=0, cnt<=0, done_o<=0, go_nogo_o<=0.
  - RUN (exactly N_PATTERNS cycles): test_mode_o=1 and prpg_o=PRPG state. PRPG advances every cycle. cnt increments. Leave when cnt==N_PATTERNS-1.
  - DRAIN: CUT_LAT cycles. Skipped when CUT_LAT=0.
  - CMP (1 cycle): signature_o<=MISR, go_nogo_o<=(MISR==GOLDEN_SIG), done_o<=1.
  - DONE: outputs held until the next rise, which goes to INIT.
- busy_o = 1 in INIT, RUN, DRAIN and CMP.
- PRPG: next = (s>>1) ^ (s[0] ? PRPG_POLY : 0). A zero seed is replaced by 1. prpg_o is 0 outside RUN.
- Capture: a CUT_LAT-deep valid shift register is loaded with 1 during each RUN cycle.
- MISR: when the delayed valid is 1, next = ((m>>1) ^ (m[0] ? MISR_POLY : 0)) ^ cut_resp_i. Exactly N_PATTERNS responses are absorbed per run.
- Widths: cnt is $clog2(N_PATTERNS+1) bits. With N_PATTERNS=1 there is 1 RUN cycle.
- Reset mid-run returns to IDLE immediately with reset values; the result is discarded.
- start_i held high continuously gives exactly one run.

Decomposition:
- lbist_pkg holds:
  - the state enum (IDLE, INIT, RUN, DRAIN, CMP, DONE);
  - default polynomial and seed constants;
  - function galois_step(state, poly).
- One sub-module, lbist_lfsr (params W, POLY). Inputs: load, load_val, en, xor_in. Output: state. It is instantiated twice: as PRPG with xor_in=0, and as MISR with xor_in=cut_resp_i.

Test Plan:
- PRPG sequence. Setup: defaults, N_PATTERNS=4, CUT_LAT=1, CUT = loopback (cut_resp_i = prpg_o registered once), one-cycle start pulse. Required: prpg_o in RUN = 32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001; test_mode_o high 5 cycles; done_o rises 8 cycles after start.
- Golden match. Setup: as above, GOLDEN_SIG set to the reference-model MISR of those 4 words. Required: done_o=1, go_nogo_o=1, signature_o=GOLDEN_SIG, held until next start.
- Fault detection. Setup: flip cut_resp_i bit 0 on the 2nd response. Required: go_nogo_o=0, done_o=1, signature_o differs from golden.
- Start robustness. Setup: pulse start_i during RUN; also hold start_i=1 for 20 cycles. Required: no restart, exactly 4 RUN cycles; a second pulse in DONE clears done_o in INIT and reproduces an identical signature.
- Reset mid-run. Setup: assert rst_n=0 at the 2nd RUN cycle. Required: all outputs 0 asynchronously, FSM=IDLE; a subsequent start gives a full correct run.
- Latency and boundary. Setup: CUT_LAT=0 and CUT_LAT=3 with N_PATTERNS=1. Required: DRAIN lasts 0 and 3 cycles respectively; MISR absorbs exactly 1 response; signature matches the model.
